// File: rtl/scan_doubler.sv
// Line-doubling scan converter: a write port fills a ring of line banks at the
// input pixel rate, and a read port at twice that rate shows each stored line
// twice. The second showing can optionally be dimmed or blanked, and the read
// port generates its own hsync, vsync and line2 markers.
module scan_doubler #(
  parameter int COMP_W    = 4,
  parameter int ADDR_W    = 10,
  parameter int NBUF_LOG2 = 2,
  parameter int HS_START  = 1,
  parameter int HS_END    = 68,
  parameter int VS_LINES  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sol,
  input  logic                wr_sof,
  input  logic [3*COMP_W-1:0] wr_pix,
  input  logic                rd_en,
  input  logic [1:0]          scan_mode,
  output logic [3*COMP_W-1:0] out_pix,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_line2,
  output logic                ovf,
  output logic                unf
);

  localparam int PIX_W = 3 * COMP_W;
  localparam int NBANK = 1 << NBUF_LOG2;
  localparam int AW    = NBUF_LOG2 + ADDR_W;
  localparam int DEPTH = 1 << AW;
  localparam int VS_W  = $clog2(VS_LINES + 1);
  localparam logic [ADDR_W:0] LINE_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [VS_W-1:0] VS_INIT  = VS_W'(VS_LINES);

  // line storage, addressed {bank, x}; contents survive reset
  logic [PIX_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]  len [NBANK];

  // write side
  logic [NBUF_LOG2-1:0] wr_bank, wr_bank_inc, sof_bank;
  logic [ADDR_W:0]      wr_x;
  logic [AW-1:0]        wr_addr;
  logic                 wr_we;
  logic                 sof_pending;

  // read side
  logic [NBUF_LOG2-1:0] rd_bank, rd_bank_nxt;
  logic [ADDR_W-1:0]    rd_x;
  logic [ADDR_W:0]      rd_len, rd_last;
  logic                 pass, eop;
  logic [1:0]           mode_q;
  logic [VS_W-1:0]      vs_cnt;

  // stage between RAM read and output registers
  logic [PIX_W-1:0]  rd_data, shaped;
  logic [ADDR_W-1:0] rx_q;
  logic              pass_q, vs_q;
  logic [1:0]        mode_s;

  // write address: a start-of-line always lands at x=0 of the next bank
  always_comb begin
    wr_bank_inc = wr_bank + NBUF_LOG2'(1);
    wr_we       = wr_en & (wr_sol | ~wr_x[ADDR_W]);
    wr_addr     = wr_sol ? {wr_bank_inc, {ADDR_W{1'b0}}}
                         : {wr_bank, wr_x[ADDR_W-1:0]};
  end

  // read length and end-of-pass; a zero length means a full bank
  always_comb begin
    rd_len  = len[rd_bank];
    rd_last = (rd_len == '0) ? LINE_MAX - (ADDR_W+1)'(1)
                             : rd_len - (ADDR_W+1)'(1);
    eop     = rd_en & ({1'b0, rd_x} == rd_last);
    if (sof_pending)
      rd_bank_nxt = sof_bank - NBUF_LOG2'(1);
    else if (pass)
      rd_bank_nxt = rd_bank + NBUF_LOG2'(1);
    else
      rd_bank_nxt = rd_bank;
  end

  // RAM write and registered read; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_we) mem[wr_addr] <= wr_pix;
    if (rd_en) rd_data <= mem[{rd_bank, rd_x}];
  end

  // write-side state, bank lengths, overflow and frame-start handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= '0;
      wr_x        <= '0;
      ovf         <= 1'b0;
      sof_bank    <= '0;
      sof_pending <= 1'b0;
      for (int b = 0; b < NBANK; b++) len[b] <= '0;
    end else begin
      if (wr_en) begin
        if (wr_sol) begin
          len[wr_bank] <= wr_x;
          wr_bank      <= wr_bank_inc;
          wr_x         <= (ADDR_W+1)'(1);
        end else if (!wr_x[ADDR_W]) begin
          wr_x <= wr_x + (ADDR_W+1)'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
      // a new frame start wins over the reader consuming the old one
      if (wr_en & wr_sol & wr_sof) begin
        sof_pending <= 1'b1;
        sof_bank    <= wr_bank_inc;
      end else if (eop & sof_pending) begin
        sof_pending <= 1'b0;
      end
    end
  end

  // read pointer, pass toggle, vsync counter, mode latch and underrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= '0;
      rd_x    <= '0;
      pass    <= 1'b0;
      mode_q  <= 2'd0;
      vs_cnt  <= '0;
      unf     <= 1'b0;
    end else if (rd_en) begin
      if (eop) begin
        rd_x    <= '0;
        rd_bank <= rd_bank_nxt;
        mode_q  <= scan_mode;
        if (rd_bank_nxt == wr_bank) unf <= 1'b1;
        if (sof_pending) begin
          pass   <= 1'b0;
          vs_cnt <= VS_INIT;
        end else begin
          pass <= ~pass;
          if (vs_cnt != '0) vs_cnt <= vs_cnt - VS_W'(1);
        end
      end else begin
        rd_x <= rd_x + ADDR_W'(1);
      end
    end
  end

  // attributes that travel alongside the RAM read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q   <= '0;
      pass_q <= 1'b0;
      vs_q   <= 1'b0;
      mode_s <= 2'd0;
    end else if (rd_en) begin
      rx_q   <= rd_x;
      pass_q <= pass;
      vs_q   <= (vs_cnt != '0);
      mode_s <= mode_q;
    end
  end

  // second-pass shading: halve every component, or blank the pixel
  always_comb begin
    shaped = rd_data;
    if (pass_q) begin
      case (mode_s)
        2'd1: for (int c = 0; c < 3; c++)
                shaped[c*COMP_W +: COMP_W] = rd_data[c*COMP_W +: COMP_W] >> 1;
        2'd2: shaped = '0;
        default: ;
      endcase
    end
  end

  // output registers, all advancing together on the read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pix   <= '0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_line2 <= 1'b0;
    end else if (rd_en) begin
      out_pix   <= shaped;
      out_hsync <= (32'(rx_q) >= HS_START) && (32'(rx_q) < HS_END);
      out_vsync <= vs_q;
      out_line2 <= pass_q;
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
// Directed bench for scan_doubler: 4-pixel lines in 16-pixel banks, four
// banks, hsync window x=1..2, six vsync lines.
module tb_scan_doubler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sol, wr_sof, rd_en;
  logic [11:0] wr_pix;
  logic [1:0]  scan_mode;
  logic [11:0] out_pix;
  logic        out_hsync, out_vsync, out_line2, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  scan_doubler #(.COMP_W(4), .ADDR_W(4), .NBUF_LOG2(2), .HS_START(1),
                 .HS_END(3), .VS_LINES(6)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sol(wr_sol), .wr_sof(wr_sof),
    .wr_pix(wr_pix), .rd_en(rd_en), .scan_mode(scan_mode), .out_pix(out_pix),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_line2(out_line2),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sol, input logic sof, input logic [11:0] pix);
    wr_en = 1'b1; wr_sol = sol; wr_sof = sof; wr_pix = pix;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_sol = 1'b0; wr_sof = 1'b0;
  endtask

  task automatic rd_tick();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  // one read strobe, then check the output for the pixel read one strobe earlier
  task automatic rd_chk(input string tag, input logic [11:0] pix,
                        input logic hs, input logic l2, input logic vs);
    rd_tick();
    chk(tag, {17'd0, out_pix, out_hsync, out_line2, out_vsync}, {17'd0, pix, hs, l2, vs});
  endtask

  // four output pixels of one pass; step selects value = base + x
  task automatic line_chk(input string tag, input logic [11:0] base, input logic step,
                          input logic l2, input logic vs);
    for (int x = 0; x < 4; x++)
      rd_chk(tag, step ? base + 12'(x) : base, (x == 1) || (x == 2), l2, vs);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sol = 1'b0; wr_sof = 1'b0; wr_pix = '0;
    rd_en = 1'b0; scan_mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {26'd0, out_pix == 12'd0, out_hsync, out_vsync, out_line2, ovf, unf},
        {26'd0, 1'b1, 5'd0});
    @(negedge clk) rst = 1'b0;

    // bank0 = A00..A03 (no sol), bank1 = FFF x4, bank2 = C00.., bank3 = D00..
    for (int x = 0; x < 4; x++) wr(1'b0, 1'b0, 12'hA00 + 12'(x));
    for (int x = 0; x < 4; x++) wr(x == 0, 1'b0, 12'hFFF);
    for (int x = 0; x < 4; x++) wr(x == 0, 1'b0, 12'hC00 + 12'(x));
    for (int x = 0; x < 4; x++) wr(x == 0, 1'b0, 12'hD00 + 12'(x));

    rd_tick();                                   // first RAM read, nothing out yet
    line_chk("b0p0", 12'hA00, 1'b1, 1'b0, 1'b0);
    scan_mode = 2'd1;                            // sampled at the end of b0p1
    line_chk("b0p1", 12'hA00, 1'b1, 1'b1, 1'b0);
    line_chk("b1p0_mode1", 12'hFFF, 1'b0, 1'b0, 1'b0);
    scan_mode = 2'd2;                            // mid b1p1: must not affect it
    line_chk("b1p1_dim", 12'h777, 1'b0, 1'b1, 1'b0);
    line_chk("b2p0", 12'hC00, 1'b1, 1'b0, 1'b0);
    chk("unf_clear", {31'd0, unf}, 32'd0);
    line_chk("b2p1_black", 12'h000, 1'b0, 1'b1, 1'b0);
    chk("unf_set", {31'd0, unf}, 32'd1);

    // frame start into bank0 while reading is paused
    scan_mode = 2'd0;
    wr(1'b1, 1'b1, 12'hE00);
    for (int x = 1; x < 4; x++) wr(1'b0, 1'b0, 12'hE00 + 12'(x));

    line_chk("b3p0", 12'hD00, 1'b1, 1'b0, 1'b0);
    line_chk("sof_b3p0", 12'hD00, 1'b1, 1'b0, 1'b1);
    line_chk("sof_b3p1", 12'hD00, 1'b1, 1'b1, 1'b1);
    line_chk("vs_b0p0", 12'hE00, 1'b1, 1'b0, 1'b1);
    line_chk("vs_b0p1", 12'hE00, 1'b1, 1'b1, 1'b1);
    line_chk("vs_b1p0", 12'hFFF, 1'b0, 1'b0, 1'b1);
    line_chk("vs_b1p1", 12'hFFF, 1'b0, 1'b1, 1'b1);
    line_chk("vs_end_b2p0", 12'hC00, 1'b1, 1'b0, 1'b0);
    rd_chk("b2p1_x0", 12'hC00, 1'b0, 1'b1, 1'b0);
    rd_chk("b2p1_x1", 12'hC01, 1'b1, 1'b1, 1'b0);

    // reset between clock edges clears everything at once
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst", {26'd0, out_pix == 12'd0, out_hsync, out_vsync, out_line2, ovf, unf},
        {26'd0, 1'b1, 5'd0});
    @(negedge clk) rst = 1'b0;

    // overflow: 16 slots per bank, the 17th write is dropped
    for (int i = 0; i < 16; i++) wr(1'b0, 1'b0, 12'(i));
    chk("ovf_16", {31'd0, ovf}, 32'd0);
    wr(1'b0, 1'b0, 12'h011);
    chk("ovf_17", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 3; i++) wr(1'b0, 1'b0, 12'h022);
    chk("ovf_20", {31'd0, ovf}, 32'd1);
    wr(1'b1, 1'b0, 12'h033);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("ovf_rst", {31'd0, ovf}, 32'd0);
    @(negedge clk) rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_doubler.md
SCAN_DOUBLER -- requirements
Module: scan_doubler

Interface
REQ-001 Parameter COMP_W, default 4: bits per colour component; pixel width PIX_W = 3*COMP_W, ordered R,G,B from MSB.
REQ-002 Parameter ADDR_W, default 10: line buffer depth 2^ADDR_W pixels per bank.
REQ-003 Parameter NBUF_LOG2, default 2: 2^NBUF_LOG2 line banks; minimum value 1.
REQ-004 Parameters HS_START, default 1, and HS_END, default 68: output hsync window in read pixel ticks.
REQ-005 Parameter VS_LINES, default 6: output vsync length in output lines.
REQ-006 clk  in  1  single system clock; all logic is synchronous to its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 wr_en  in  1  write-side pixel strobe, 14 MHz rate.
REQ-009 wr_sol  in  1  start-of-line marker, qualified by wr_en.
REQ-010 wr_sof  in  1  start-of-frame marker, qualified by wr_en & wr_sol.
REQ-011 wr_pix  in  PIX_W  input pixel.
REQ-012 rd_en  in  1  read-side pixel strobe, nominally 2x the wr_en rate.
REQ-013 scan_mode  in  2  0 = plain doubling; 1 = second pass dimmed 50%; 2 = second pass black; 3 = same as 0.
REQ-014 out_pix  out  PIX_W  doubled pixel.
REQ-015 out_hsync / out_vsync / out_line2  out  1 each  active-high syncs; out_line2 marks the second pass.
REQ-016 ovf / unf  out  1 each  sticky write-overflow and read-underrun flags.

Function
REQ-017 Storage: 2^(NBUF_LOG2+ADDR_W) x PIX_W RAM addressed {bank, x}; per-bank length register len[bank] of ADDR_W+1 bits.
REQ-018 Write, wr_en & wr_sol: len[wr_bank] <= wr_x; wr_bank <= wr_bank+1 (wraps); pixel stored at {wr_bank+1, 0}; wr_x <= 1.
REQ-019 Write, wr_en & !wr_sol & wr_x < 2^ADDR_W: pixel stored at {wr_bank, wr_x}; wr_x <= wr_x+1.
REQ-020 Write, wr_en & !wr_sol & wr_x == 2^ADDR_W: pixel dropped, wr_x held, ovf <= 1.
REQ-021 wr_sof with wr_en & wr_sol: sof_pending <= 1; sof_bank <= new wr_bank value.
REQ-022 Read, on rd_en: effective length L = len[rd_bank], or 2^ADDR_W if that value is 0; if rd_x == L-1, end-of-pass occurs, else rd_x <= rd_x+1.
REQ-023 End-of-pass, no sof_pending: rd_x <= 0; pass toggles; when pass was 1, rd_bank <= rd_bank+1.
REQ-024 End-of-pass, sof_pending set: rd_x <= 0; pass <= 0; rd_bank <= sof_bank-1; sof_pending <= 0; vs_cnt <= VS_LINES. This takes priority over REQ-023.
REQ-025 Simultaneous wr_sof arrival and end-of-pass in the same clock: the end-of-pass sees the old sof_pending; the new frame is taken at the next end-of-pass.
REQ-026 Underrun: at any end-of-pass whose next rd_bank equals the current wr_bank, unf <= 1; reading continues regardless.
REQ-027 Output pipeline, one rd_en tick latency: on rd_en, RAM is read at {rd_bank, rd_x}; out_pix, out_hsync, out_line2 and out_vsync update together on the following rd_en.
REQ-028 out_hsync = 1 when the registered rd_x lies in [HS_START, HS_END), else 0.
REQ-029 out_vsync = 1 while vs_cnt != 0; vs_cnt decrements at each end-of-pass, saturating at 0.
REQ-030 Scanline modes on pass 1: mode 1 shifts each component right by 1 (0xF -> 0x7); mode 2 forces out_pix to 0; pass 0 is always unmodified.
REQ-031 scan_mode is sampled at each end-of-pass only; mid-line changes take effect on the next pass.
REQ-032 No rd_en: all read-side state and outputs hold; wr_en and rd_en asserted in the same clock are both honoured.

Reset
REQ-033 rst asserted: wr_bank, wr_x, rd_bank, rd_x, pass, vs_cnt, sof_pending, ovf, unf, all len[], out_pix, out_hsync, out_vsync and out_line2 go to 0 immediately, independent of clk.
REQ-034 RAM contents are not reset; after rst, out_pix carries undefined data only until the first bank written after reset is read.
REQ-035 A reset asserted mid-line discards that line; after release, the first wr_sol starts bank 1.

Verification
REQ-036 Lines of 640 pixels, value = x, one rd_en per clk, one wr_en per 2 clk, mode 0 -> each line is output twice, out_pix = 0..639, out_line2 = 0 then 1, out_hsync high for x = 1..67.
REQ-037 Mode 1 with wr_pix = 12'hFFF -> pass 0 = 12'hFFF, pass 1 = 12'h777; mode 2 -> pass 1 = 12'h000.
REQ-038 ADDR_W = 4, 20 wr_en without wr_sol -> ovf = 1 after the 17th write; len stays 16; ovf stays 1 until rst.
REQ-039 wr_sof, then next end-of-pass -> rd_bank = sof_bank-1, out_vsync high for exactly 6 output lines, pass restarts at 0.
REQ-040 Stop wr_en while rd_en continues -> unf = 1 once rd_bank reaches wr_bank; assert rst mid-line -> all outputs 0 at once, no clk edge required.
